// File: rtl/uart_phy_ctrl_pkg.sv
// Shared UART PHY defaults and types; uart_usrapp derives its timeout from the same
// clock/baud values so the two blocks never disagree.
package uart_phy_ctrl_pkg;

    localparam int unsigned UART_CLK_FREQ  = 50_000_000;
    localparam int unsigned UART_BAUD_RATE = 115200;

    typedef logic [7:0] uart_byte_t;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_phy_ctrl_if.sv
// Byte-level handshake between uart_usrapp (master) and the UART PHY (slave).
interface uart_phy_ctrl_if;
    import uart_phy_ctrl_pkg::*;

    logic       usr_start_tx;
    uart_byte_t usr_data_tx;
    logic       usr_done_tx;
    logic       usr_done_rx;
    uart_byte_t usr_data_rx;
    logic       rx_frame_err;

    modport master (
        output usr_start_tx, usr_data_tx,
        input  usr_done_tx, usr_done_rx, usr_data_rx, rx_frame_err
    );

    modport slave (
        input  usr_start_tx, usr_data_tx,
        output usr_done_tx, usr_done_rx, usr_data_rx, rx_frame_err
    );

endinterface

// File: rtl/uart_phy_ctrl_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM and byte assembly.
module uart_phy_rx
    import uart_phy_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic       usr_done_rx,
    output uart_byte_t usr_data_rx,
    output logic       rx_frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;

    rx_state_t   state, state_nxt;
    logic        rxd_m, rxd_s;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    uart_byte_t  shreg, shreg_nxt;
    uart_byte_t  data_nxt;
    logic        done_nxt, err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m        <= 1'b1;
            rxd_s        <= 1'b1;
            state        <= R_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            usr_data_rx  <= '0;
            usr_done_rx  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rxd_m        <= uart_rxd;
            rxd_s        <= rxd_m;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            shreg        <= shreg_nxt;
            usr_data_rx  <= data_nxt;
            usr_done_rx  <= done_nxt;
            rx_frame_err <= err_nxt;
        end
    end

    // Down-counter: loaded with half a bit at the start edge, then a full bit, so every
    // decision falls at mid-bit of the synchronized line.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = usr_data_rx;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            R_IDLE: begin
                if (!rxd_s) begin
                    state_nxt = R_START;
                    cnt_nxt   = CNT_W'(CLKS_PER_BIT / 2);
                end
            end
            R_START: begin
                if (cnt == '0) begin
                    if (rxd_s) begin
                        state_nxt = R_IDLE;
                    end else begin
                        state_nxt = R_DATA;
                        cnt_nxt   = CNT_W'(CLKS_PER_BIT - 1);
                        idx_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            R_DATA: begin
                if (cnt == '0) begin
                    shreg_nxt = {rxd_s, shreg[7:1]};
                    cnt_nxt   = CNT_W'(CLKS_PER_BIT - 1);
                    if (idx == 3'd7) state_nxt = R_STOP;
                    else             idx_nxt   = idx + 3'd1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            R_STOP: begin
                if (cnt == '0) begin
                    if (rxd_s) begin
                        state_nxt = R_IDLE;
                        data_nxt  = shreg;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = R_BREAK;
                        err_nxt   = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            R_BREAK: begin
                if (rxd_s) state_nxt = R_IDLE;
            end
            default: state_nxt = R_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_phy_ctrl.sv
// 8N1 UART PHY: inline TX serializer plus uart_phy_rx, handshaking with uart_usrapp
// through uart_phy_ctrl_if.
module uart_phy_ctrl
    import uart_phy_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = UART_CLK_FREQ,
    parameter int unsigned BAUD_RATE = UART_BAUD_RATE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_rxd,
    output logic            uart_txd,
    uart_phy_ctrl_if.slave  usr
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    if (CLKS_PER_BIT < 8) begin : g_cpb_check
        $error("uart_phy_ctrl: CLK_FREQ/BAUD_RATE must be >= 8");
    end

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    uart_byte_t       shreg, shreg_nxt;
    logic             txd_q, txd_nxt;
    logic             done_q, done_nxt;
    logic             bit_end;

    assign uart_txd        = txd_q;
    assign usr.usr_done_tx = done_q;
    assign bit_end         = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= T_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            txd_q  <= 1'b1;
            done_q <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shreg  <= shreg_nxt;
            txd_q  <= txd_nxt;
            done_q <= done_nxt;
        end
    end

    // txd is registered one step ahead: each bit boundary loads the next line level,
    // so the shift register's bit 1 is the bit about to go out.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        txd_nxt   = txd_q;
        done_nxt  = done_q;
        unique case (state)
            T_IDLE: begin
                if (usr.usr_start_tx) begin
                    state_nxt = T_START;
                    shreg_nxt = usr.usr_data_tx;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    txd_nxt   = 1'b0;
                    done_nxt  = 1'b0;
                end
            end
            T_START: begin
                if (bit_end) begin
                    state_nxt = T_DATA;
                    cnt_nxt   = '0;
                    txd_nxt   = shreg[0];
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            T_DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (idx == 3'd7) begin
                        state_nxt = T_STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        shreg_nxt = {1'b0, shreg[7:1]};
                        txd_nxt   = shreg[1];
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            T_STOP: begin
                if (bit_end) begin
                    state_nxt = T_IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = T_IDLE;
        endcase
    end

    uart_phy_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .uart_rxd    (uart_rxd),
        .usr_done_rx (usr.usr_done_rx),
        .usr_data_rx (usr.usr_data_rx),
        .rx_frame_err(usr.rx_frame_err)
    );

endmodule

// File: tb/tb_uart_phy_ctrl.sv
// Directed bench for uart_phy_ctrl at CLKS_PER_BIT = 10.
module tb_uart_phy_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;
    logic txd;
    logic rxd_line;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rx_cnt   = 0;
    int err_cnt  = 0;
    int rx_done_cyc  = 0;
    int rx_start_cyc = 0;

    uart_phy_ctrl_if usr_if ();

    assign rxd_line = loop_en ? txd : rxd_drv;

    uart_phy_ctrl #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rxd(rxd_line),
        .uart_txd(txd),
        .usr     (usr_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (usr_if.usr_done_rx) begin
            rx_cnt      = rx_cnt + 1;
            rx_done_cyc = cyc;
        end
        if (usr_if.rx_frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called just after a negedge; the start pulse is taken at the following posedge.
    task automatic tx_start(input logic [7:0] d);
        usr_if.usr_data_tx  = d;
        usr_if.usr_start_tx = 1'b1;
        @(posedge clk);
        #1 usr_if.usr_start_tx = 1'b0;
    endtask

    task automatic tx_check(input string tag, input logic [7:0] d, input int ignore_at);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (k == ignore_at) begin
                usr_if.usr_start_tx = 1'b1;
                usr_if.usr_data_tx  = 8'hFF;
            end else if (k == ignore_at + 1) begin
                usr_if.usr_start_tx = 1'b0;
            end
            if (k < 100) begin
                check_eq($sformatf("%s_txd_%0d", tag, k), {31'd0, txd}, {31'd0, frame[k/10]});
                check_eq($sformatf("%s_done_%0d", tag, k), {31'd0, usr_if.usr_done_tx}, 32'd0);
            end else begin
                check_eq($sformatf("%s_txd_end", tag), {31'd0, txd}, 32'd1);
                check_eq($sformatf("%s_done_end", tag), {31'd0, usr_if.usr_done_tx}, 32'd1);
            end
        end
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        rx_start_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            rxd_drv = f[b];
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic rx_expect(input string tag, input logic [7:0] d, input int prev_cnt);
        check_eq({tag, "_cnt"}, rx_cnt, prev_cnt + 1);
        check_eq({tag, "_data"}, {24'd0, usr_if.usr_data_rx}, {24'd0, d});
        check_eq({tag, "_lat"}, rx_done_cyc - (rx_start_cyc + 1), 32'd98);
    endtask

    initial begin
        int rc;
        int ec;
        usr_if.usr_start_tx = 1'b0;
        usr_if.usr_data_tx  = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        check_eq("rst_txd", {31'd0, txd}, 32'd1);
        check_eq("rst_done_tx", {31'd0, usr_if.usr_done_tx}, 32'd1);
        check_eq("rst_done_rx", {31'd0, usr_if.usr_done_rx}, 32'd0);
        check_eq("rst_data_rx", {24'd0, usr_if.usr_data_rx}, 32'd0);
        check_eq("rst_frame_err", {31'd0, usr_if.rx_frame_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single frame
        tx_start(8'hA5);
        tx_check("tx1", 8'hA5, -1);

        // 2: back-to-back frames, start while busy ignored
        repeat (5) @(negedge clk);
        tx_start(8'h11);
        tx_check("tx2a", 8'h11, 50);
        tx_start(8'h22);
        tx_check("tx2b", 8'h22, -1);

        // 3: back-to-back receive
        repeat (5) @(negedge clk);
        rc = rx_cnt;
        rx_send(8'h3C, 1'b1);
        rx_expect("rx3a", 8'h3C, rc);
        rx_send(8'hC3, 1'b1);
        rx_expect("rx3b", 8'hC3, rc + 1);

        // 4: short low glitch, then a good byte
        repeat (20) @(negedge clk);
        rc = rx_cnt;
        ec = err_cnt;
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("rx4_glitch_cnt", rx_cnt, rc);
        check_eq("rx4_glitch_err", err_cnt, ec);
        rx_send(8'h55, 1'b1);
        rx_expect("rx4", 8'h55, rc);

        // 5: bad stop bit with line held low
        repeat (10) @(negedge clk);
        rc = rx_cnt;
        ec = err_cnt;
        rx_send(8'h7E, 1'b0);
        repeat (30) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("rx5_err_cnt", err_cnt, ec + 1);
        check_eq("rx5_done_cnt", rx_cnt, rc);
        check_eq("rx5_data_kept", {24'd0, usr_if.usr_data_rx}, 32'h55);
        rx_send(8'h81, 1'b1);
        rx_expect("rx5", 8'h81, rc);

        // 6: reset mid-frame on both paths
        repeat (10) @(negedge clk);
        rc = rx_cnt;
        ec = err_cnt;
        fork
            rx_send(8'h99, 1'b1);
            begin
                repeat (5) @(negedge clk);
                tx_start(8'h33);
                repeat (34) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check_eq("rst6_txd", {31'd0, txd}, 32'd1);
                check_eq("rst6_done_tx", {31'd0, usr_if.usr_done_tx}, 32'd1);
                check_eq("rst6_done_rx", {31'd0, usr_if.usr_done_rx}, 32'd0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("rst6_rx_cnt", rx_cnt, rc);
        check_eq("rst6_err_cnt", err_cnt, ec);
        check_eq("rst6_data_rx", {24'd0, usr_if.usr_data_rx}, 32'd0);

        // loopback after reset
        loop_en = 1'b1;
        tx_start(8'h5A);
        for (int i = 0; i < 200 && rx_cnt == rc; i++) @(negedge clk);
        check_eq("loop_cnt", rx_cnt, rc + 1);
        check_eq("loop_data", {24'd0, usr_if.usr_data_rx}, 32'h5A);
        for (int i = 0; i < 50 && !usr_if.usr_done_tx; i++) @(negedge clk);
        check_eq("loop_done_tx", {31'd0, usr_if.usr_done_tx}, 32'd1);
        check_eq("loop_err_cnt", err_cnt, ec);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
